// File: rtl/aes128_pkg.sv
// aes128_pkg: shared AES-128 types, Rcon table and GF(2^8)/S-box helpers
package aes128_pkg;
    localparam int NR = 10;
    typedef logic [0:15][7:0] block_t;
    localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction
endpackage

// File: rtl/main_if.sv
// main_if: bundle of the decryptor key, ciphertext and plaintext buses
interface main_if;
    import aes128_pkg::*;
    block_t key;
    block_t in_text;
    block_t out_text;
    modport master (output key, output in_text, input out_text);
    modport slave (input key, input in_text, output out_text);
endinterface

// File: rtl/aes128_key_expand.sv
// aes128_key_expand: combinational AES-128 key schedule, key -> rk0..rk10
module aes128_key_expand
    import aes128_pkg::*;
(
    input  block_t         key,
    output block_t [0:NR]  rk
);
    function automatic block_t next_rk(block_t p, logic [7:0] rc);
        block_t n;
        logic [0:3][7:0] t;
        t = {sbox(p[13]) ^ rc, sbox(p[14]), sbox(p[15]), sbox(p[12])};
        for (int i = 0; i < 4; i++) n[i] = p[i] ^ t[i];
        for (int i = 4; i < 16; i++) n[i] = p[i] ^ n[i-4];
        return n;
    endfunction

    always_comb begin
        rk[0] = key;
        for (int r = 1; r <= NR; r++) rk[r] = next_rk(rk[r-1], RCON[r-1]);
    end
endmodule

// File: rtl/main.sv
// main: AES-128 InvCipher, 1-cycle latency; MAIN_IN_REG_EN adds input registers (2-cycle latency)
module main
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] key,
    input  logic [0:127] inText,
    output logic [0:127] outText
);
    localparam logic [7:0] IMC [0:3] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    block_t key_s, text_s, st, out_text_d, out_text_q;
    block_t [0:NR] rk;
    logic vld_s;

`ifdef MAIN_IN_REG_EN
    block_t key_d, key_q, text_d, text_q;
    logic vld_d, vld_q;
    always_comb begin
        key_d = key;
        text_d = inText;
        vld_d = 1'b1;
    end
    always_ff @(posedge clk) begin
        key_q <= reset ? '0 : key_d;
        text_q <= reset ? '0 : text_d;
        vld_q <= reset ? 1'b0 : vld_d;
    end
    assign key_s = key_q;
    assign text_s = text_q;
    assign vld_s = vld_q;
`else
    assign key_s = key;
    assign text_s = inText;
    assign vld_s = 1'b1;
`endif

    aes128_key_expand u_key_expand (.key(key_s), .rk(rk));

    function automatic block_t inv_shift(block_t s);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[4*c+r] = s[4*((c-r+4)%4)+r];
        return o;
    endfunction

    function automatic block_t inv_sub(block_t s);
        block_t o;
        for (int i = 0; i < 16; i++) o[i] = inv_sbox(s[i]);
        return o;
    endfunction

    function automatic block_t inv_mix(block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++) o[4*c+r] ^= gf_mul(IMC[(j-r+4)%4], s[4*c+j]);
        return o;
    endfunction

    // the input-register stage reports invalid until it has captured a non-reset block
    always_comb begin
        st = text_s ^ rk[NR];
        for (int r = NR - 1; r >= 0; r--) begin
            st = inv_sub(inv_shift(st)) ^ rk[r];
            if (r > 0) st = inv_mix(st);
        end
        out_text_d = vld_s ? st : '0;
    end

    always_ff @(posedge clk) out_text_q <= reset ? '0 : out_text_d;

    assign outText = out_text_q;
endmodule

// File: tb/tb_main.sv
// tb_main: scoreboard bench for main using FIPS-197 vectors, reset and back-to-back streams
module tb_main;
    import aes128_pkg::*;
`ifdef MAIN_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 18;

    typedef struct packed {
        logic [127:0] k;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    main_if bus();

    main dut (.clk(clk), .reset(reset), .key(bus.key), .inText(bus.in_text), .outText(bus.out_text));

    always #5 clk = ~clk;

    vec_t tv [3];
    logic seq_rst [N] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int   seq_idx [N] = '{0, 0, 0, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0, 2, 2, 0, 1, 0};
    logic [127:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    initial begin
        logic prev_rst;
        logic [127:0] prev_pt, cur_pt, exp_v;
        tv[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        tv[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        tv[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
        reset = 1'b1;
        bus.key = '0;
        bus.in_text = '0;
        prev_rst = 1'b1;
        prev_pt = '0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            reset = seq_rst[i];
            bus.key = tv[seq_idx[i]].k;
            bus.in_text = tv[seq_idx[i]].ct;
            cur_pt = tv[seq_idx[i]].pt;
            exp_v = seq_rst[i] ? '0 : (LAT == 1 ? cur_pt : (prev_rst ? '0 : prev_pt));
            exp_q.push_back(exp_v);
            prev_rst = seq_rst[i];
            prev_pt = cur_pt;
        end
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [127:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if (bus.out_text !== exp_v) begin
                    $display("FAIL out_text step %0d: got %h want %h", n_vec, bus.out_text, exp_v);
                    n_err++;
                end
            end
        end
    end
endmodule
